tinyfpga_bx_pll_ctrl: RTL

TINYFPGA_BX_PLL_CTRL -- requirements
Module: tinyfpga_bx_pll_ctrl

---
 rtl/tinyfpga_bx_pll_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tinyfpga_bx_pll_ctrl.sv
// PLL reset/lock sequencer for the TinyFPGA BX: holds the PLL in reset, qualifies lock, releases downstream reset.
// Define PLL_CTRL_BYPASS_FALLBACK_EN to run on the bypassed reference clock instead of faulting when retries run out.
module tinyfpga_bx_pll_ctrl #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65535,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOCK,
  input  logic       RESTART,
  output logic       PLL_RESETB,
  output logic       PLL_BYPASS,
  output logic       SYS_RESETN,
  output logic       READY,
  output logic       FAULT,
  output logic [1:0] RETRY_CNT,
  output logic [7:0] LOSS_CNT
);

  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0]   TO_LAST   = 16'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAULT
`ifdef PLL_CTRL_BYPASS_FALLBACK_EN
    , S_BYPASS
`endif
  } state_t;

`ifdef PLL_CTRL_BYPASS_FALLBACK_EN
  localparam state_t S_EXHAUST = S_BYPASS;
`else
  localparam state_t S_EXHAUST = S_FAULT;
`endif

  state_t          state, nxt;
  logic            lock_m, lock_s;
  logic [HW-1:0]   hold_cnt;
  logic [SW-1:0]   stab_cnt;
  logic [15:0]     to_cnt;
  logic [1:0]      retry, retry_d;
  logic [7:0]      loss, loss_d;
  logic            timeout, in_attempt, nxt_attempt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= LOCK;
      lock_s <= lock_m;
    end
  end

  // The timeout budget covers the whole attempt, so lock glitches that bounce
  // between WAIT and STABLE cannot extend it.
  assign timeout     = (to_cnt == TO_LAST);
  assign in_attempt  = (state == S_WAIT) || (state == S_STABLE);
  assign nxt_attempt = (nxt == S_WAIT) || (nxt == S_STABLE);

  always_comb begin
    nxt     = state;
    retry_d = retry;
    loss_d  = loss;
    if (RESTART) begin
      nxt     = S_HOLD;
      retry_d = '0;
    end else begin
      case (state)
        S_HOLD:   if (hold_cnt == HOLD_LAST) nxt = S_WAIT;
        S_WAIT: begin
          if (timeout) begin
            if (retry < RETRY_MAX) begin
              nxt     = S_HOLD;
              retry_d = retry + 2'd1;
            end else begin
              nxt = S_EXHAUST;
            end
          end else if (lock_s) begin
            nxt = S_STABLE;
          end
        end
        S_STABLE: begin
          if (lock_s && stab_cnt == STAB_LAST) begin
            nxt     = S_RUN;
            retry_d = '0;
          end else if (timeout) begin
            if (retry < RETRY_MAX) begin
              nxt     = S_HOLD;
              retry_d = retry + 2'd1;
            end else begin
              nxt = S_EXHAUST;
            end
          end else if (!lock_s) begin
            nxt = S_WAIT;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            nxt = S_HOLD;
            if (loss != 8'hff) loss_d = loss + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_HOLD;
      hold_cnt <= '0;
      stab_cnt <= '0;
      to_cnt   <= '0;
      retry    <= '0;
      loss     <= '0;
    end else begin
      state    <= nxt;
      hold_cnt <= (state == S_HOLD && nxt == S_HOLD && !RESTART) ? hold_cnt + 1'b1 : '0;
      stab_cnt <= (state == S_STABLE && nxt == S_STABLE) ? stab_cnt + 1'b1 : '0;
      to_cnt   <= (in_attempt && nxt_attempt) ? to_cnt + 1'b1 : '0;
      retry    <= retry_d;
      loss     <= loss_d;
    end
  end

  // Outputs are decoded from the registered state, so they trail it by a cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PLL_RESETB <= 1'b0;
      SYS_RESETN <= 1'b0;
      READY      <= 1'b0;
      FAULT      <= 1'b0;
      RETRY_CNT  <= '0;
      LOSS_CNT   <= '0;
    end else begin
      PLL_RESETB <= in_attempt || state == S_RUN;
      SYS_RESETN <= state == S_RUN;
      READY      <= state == S_RUN;
      FAULT      <= state == S_FAULT;
      RETRY_CNT  <= retry;
      LOSS_CNT   <= loss;
`ifdef PLL_CTRL_BYPASS_FALLBACK_EN
      if (state == S_BYPASS) begin
        PLL_RESETB <= 1'b1;
        SYS_RESETN <= 1'b1;
        FAULT      <= 1'b1;
      end
`endif
    end
  end

`ifdef PLL_CTRL_BYPASS_FALLBACK_EN
  logic bypass_q;
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) bypass_q <= 1'b0;
    else        bypass_q <= state == S_BYPASS;
  end
  assign PLL_BYPASS = bypass_q;
`else
  assign PLL_BYPASS = 1'b0;
`endif

endmodule
